misaligned_ram_port: RTL

//  Byte-lane alignment front end for the word-organised ExtendRAM. Accepts byte-addressed load/store

---
 rtl/misaligned_ram_pkg.sv | 35 +++
 rtl/lane_rotate.sv | 35 +++
 rtl/misaligned_ram_port.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/misaligned_ram_pkg.sv
// ============================================================================
// Module : misaligned_ram_pkg
// Brief  : Shared types and helpers for the misaligned RAM port front end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package misaligned_ram_pkg;

  // Access sequencer states: one or two RAM beats, optional read wait, response
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_e;

  localparam int ROT_LEFT  = 0;
  localparam int ROT_RIGHT = 1;
  localparam int MAX_LANES = 64;

  // Oversized requests collapse to a full word
  function automatic int unsigned clamp_size(input int unsigned size, input int unsigned log2g);
    return (size > log2g) ? log2g : size;
  endfunction

  // n contiguous lane enables starting at lane 0
  function automatic logic [MAX_LANES-1:0] unit_mask(input int unsigned n);
    return (MAX_LANES'(1) << n) - MAX_LANES'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_rotate.sv
// ============================================================================
// Module : lane_rotate
// Brief  : Combinational rotator moving whole UNITW-bit lanes left or right.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lane_rotate
  import misaligned_ram_pkg::*;
#(
  parameter int UNITW = 8,
  parameter int LANES = 4,
  parameter int DIR   = ROT_LEFT
) (
  input  logic [UNITW*LANES-1:0]   data_i,
  input  logic [$clog2(LANES)-1:0] shift_i,
  output logic [UNITW*LANES-1:0]   data_o
);

  localparam int SHW = $clog2(LANES);

  logic [LANES-1:0][UNITW-1:0] w_in;
  assign w_in = data_i;

  // Each output lane picks its source lane; LANES is a power of two so the
  // index arithmetic wraps naturally
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [SHW-1:0] w_src;
    assign w_src = (DIR == ROT_LEFT) ? (SHW'(i) - shift_i) : (SHW'(i) + shift_i);
    assign data_o[i*UNITW +: UNITW] = w_in[w_src];
  end

endmodule

`default_nettype wire

// File: rtl/misaligned_ram_port.sv
// ============================================================================
// Module : misaligned_ram_port
// Brief  : Byte-lane alignment front end for a word-organised synchronous RAM.
//          Rotates store data/enables onto lanes, splits word-crossing
//          accesses into two beats, right-aligns and extends load data.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module misaligned_ram_port
  import misaligned_ram_pkg::*;
#(
  parameter  int UNITW = 8,
  parameter  int GROUP = 4,
  parameter  int ADDRW = 32,
  localparam int OFFW  = $clog2(GROUP),
  localparam int SIZEW = $clog2($clog2(GROUP) + 1)
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     REQ_VALID,
  output logic                     REQ_READY,
  input  logic                     REQ_WE,
  input  logic                     REQ_SIGNED,
  input  logic [SIZEW-1:0]         REQ_SIZE,
  input  logic [ADDRW-1:0]         REQ_ADDR,
  input  logic [UNITW*GROUP-1:0]   REQ_WDATA,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [UNITW*GROUP-1:0]   RSP_RDATA,
  output logic                     RAM_EN,
  output logic [GROUP-1:0]         RAM_WE,
  output logic [ADDRW-OFFW-1:0]    RAM_ADDR,
  output logic [UNITW*GROUP-1:0]   RAM_WDATA,
  input  logic [UNITW*GROUP-1:0]   RAM_RDATA
);

  localparam int WORDW  = UNITW * GROUP;
  localparam int WAW    = ADDRW - OFFW;
  localparam int NW     = OFFW + 2;
  localparam int LANES2 = 2 * GROUP;

  state_e             state_q, state_d;
  logic               rdy_q, we_q, signed_q, split_q, caplo_q, caphi_q;
  logic [SIZEW-1:0]   size_q;
  logic [OFFW-1:0]    off_q;
  logic [WAW-1:0]     wa_q;
  logic [WORDW-1:0]   wdata_q, lo_q, hi_q, rdata_q;

  logic               w_accept, w_req_split, w_sign;
  logic [SIZEW-1:0]   w_req_size;
  logic [NW-1:0]      w_req_n, w_n;
  logic [LANES2-1:0]  w_mask, w_emask;
  logic [WORDW-1:0]   w_wrot, w_lo, w_hi, w_low, w_res;
  logic [2*WORDW-1:0] w_rot;
  logic [GROUP-1:0]   w_top;
  logic               w_unused;

  assign w_accept    = REQ_VALID && REQ_READY;
  assign w_req_size  = SIZEW'(clamp_size(32'(REQ_SIZE), OFFW));
  assign w_req_n     = NW'(1) << w_req_size;
  assign w_req_split = (NW'(REQ_ADDR[OFFW-1:0]) + w_req_n) > NW'(GROUP);

  assign w_n     = NW'(1) << size_q;
  assign w_mask  = LANES2'(unit_mask(32'(w_n)));
  assign w_emask = w_mask << off_q;

  // Store data lands on lanes off..off+n-1, wrapping into the HI word's low lanes
  lane_rotate #(.UNITW(UNITW), .LANES(GROUP), .DIR(ROT_LEFT)) u_wr_rot (
    .data_i  (wdata_q),
    .shift_i (off_q),
    .data_o  (w_wrot)
  );

  // The beat just read is still on RAM_RDATA; earlier beats come from capture regs
  assign w_lo = caplo_q ? RAM_RDATA : lo_q;
  assign w_hi = caphi_q ? RAM_RDATA : hi_q;

  lane_rotate #(.UNITW(UNITW), .LANES(LANES2), .DIR(ROT_RIGHT)) u_rd_rot (
    .data_i  ({w_hi, w_lo}),
    .shift_i ({1'b0, off_q}),
    .data_o  (w_rot)
  );

  assign w_low    = w_rot[WORDW-1:0];
  assign w_unused = ^w_rot[2*WORDW-1:WORDW];

  for (genvar j = 0; j < GROUP; j++) begin : g_top
    assign w_top[j] = w_low[(j+1)*UNITW-1];
  end

  assign w_sign = signed_q & w_top[OFFW'(w_n - NW'(1))];

  for (genvar i = 0; i < GROUP; i++) begin : g_res
    assign w_res[i*UNITW +: UNITW] = (NW'(i) < w_n) ? w_low[i*UNITW +: UNITW] : {UNITW{w_sign}};
  end

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state sequencing of RAM beats and the response handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept) state_d = LO;
      LO:      state_d = split_q ? HI : (we_q ? RESP : WAIT);
      HI:      state_d = we_q ? RESP : WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (RSP_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    REQ_READY = rdy_q && (state_q == IDLE);
    RSP_VALID = (state_q == RESP);
    RSP_RDATA = rdata_q;
    RAM_EN    = 1'b0;
    RAM_WE    = '0;
    RAM_ADDR  = '0;
    RAM_WDATA = '0;
    case (state_q)
      LO: begin
        RAM_EN    = 1'b1;
        RAM_ADDR  = wa_q;
        RAM_WE    = we_q ? w_emask[GROUP-1:0] : '0;
        RAM_WDATA = w_wrot;
      end
      HI: begin
        RAM_EN    = 1'b1;
        RAM_ADDR  = wa_q + WAW'(1);
        RAM_WE    = we_q ? w_emask[LANES2-1:GROUP] : '0;
        RAM_WDATA = w_wrot;
      end
      default: ;
    endcase
  end

  // Ready is held off until the first clock after reset release
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;
  end

  // Capture the request on accept; inputs are free to change afterwards
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      split_q  <= 1'b0;
      size_q   <= '0;
      off_q    <= '0;
      wa_q     <= '0;
      wdata_q  <= '0;
    end else if (w_accept) begin
      we_q     <= REQ_WE;
      signed_q <= REQ_SIGNED;
      split_q  <= w_req_split;
      size_q   <= w_req_size;
      off_q    <= REQ_ADDR[OFFW-1:0];
      wa_q     <= REQ_ADDR[ADDRW-1:OFFW];
      wdata_q  <= REQ_WDATA;
    end
  end

  // Read data arrives one cycle after each beat; latch it into the matching half
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      caplo_q <= 1'b0;
      caphi_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      caplo_q <= (state_q == LO);
      caphi_q <= (state_q == HI);
      if (caplo_q) lo_q <= RAM_RDATA;
      if (caphi_q) hi_q <= RAM_RDATA;
    end
  end

  // Response data is frozen on entry to RESP and held until consumed
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                                     rdata_q <= '0;
    else if ((state_q != RESP) && (state_d == RESP)) rdata_q <= we_q ? '0 : w_res;
  end

endmodule

`default_nettype wire
